// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 32 x 64-bit architectural register file (X31 = XZR) with a per-register pending scoreboard.
// Optional feature macro REGFILE_BYPASS_EN: same-cycle write data is forwarded to matching read ports.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [4:0]            ReadRegister1,
  input  logic [4:0]            ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  RegWrite,
  input  logic [4:0]            WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_reg,
  output logic [5:0]            busy_count
);

  localparam logic [4:0] XZR = 5'(NUM_REGS - 1);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] r_regs [0:NUM_REGS-2];
  logic [NUM_REGS-1:0]   r_pending;
  logic [5:0]            r_busy_count;
  logic [NUM_REGS-1:0]   w_pending_next;
  logic                  w_wr_en;
  logic                  w_iss_en;
  logic [DATA_WIDTH-1:0] w_stored1;
  logic [DATA_WIDTH-1:0] w_stored2;
  logic [DATA_WIDTH:0]   w_port1;
  logic [DATA_WIDTH:0]   w_port2;

  function automatic logic [5:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + {5'd0, v[i]};
    end
    return cnt;
  endfunction

  // Returns {busy, data} for one read port; XZR reads as an idle zero.
  function automatic logic [DATA_WIDTH:0] read_port(
    input logic [4:0]            idx,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  pend,
    input logic                  wr_en,
    input logic [4:0]            wr_idx,
    input logic [DATA_WIDTH-1:0] wr_data,
    input logic                  iss_hit
  );
    logic [DATA_WIDTH:0] res;
    if (idx == XZR) begin
      res = '0;
    end else if (BYPASS && wr_en && (wr_idx == idx)) begin
      res = {pend & iss_hit, wr_data};
    end else begin
      res = {pend, stored};
    end
    return res;
  endfunction

  assign w_wr_en  = RegWrite && (WriteRegister != XZR);
  assign w_iss_en = issue_valid && (issue_reg != XZR);

  // Next pending vector: an issue to the register being written back wins over the clear.
  always_comb begin
    w_pending_next = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      w_pending_next[i] = (w_iss_en && (issue_reg == 5'(i))) ? 1'b1 :
                          (w_wr_en && (WriteRegister == 5'(i))) ? 1'b0 : r_pending[i];
    end
  end

  // Register storage; XZR has no backing flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[WriteRegister] <= WriteData;
    end
  end

  // Scoreboard state and its registered population count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pending    <= '0;
      r_busy_count <= 6'd0;
    end else begin
      r_pending    <= w_pending_next;
      r_busy_count <= popcount(w_pending_next);
    end
  end

  assign w_stored1 = (ReadRegister1 == XZR) ? '0 : r_regs[ReadRegister1];
  assign w_stored2 = (ReadRegister2 == XZR) ? '0 : r_regs[ReadRegister2];

  assign w_port1 = read_port(ReadRegister1, w_stored1, r_pending[ReadRegister1], w_wr_en,
                             WriteRegister, WriteData, w_iss_en && (issue_reg == ReadRegister1));
  assign w_port2 = read_port(ReadRegister2, w_stored2, r_pending[ReadRegister2], w_wr_en,
                             WriteRegister, WriteData, w_iss_en && (issue_reg == ReadRegister2));

  assign ReadData1  = w_port1[DATA_WIDTH-1:0];
  assign busy1      = w_port1[DATA_WIDTH];
  assign ReadData2  = w_port2[DATA_WIDTH-1:0];
  assign busy2      = w_port2[DATA_WIDTH];
  assign busy_count = r_busy_count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus random traffic against a
// behavioural model of register contents and pending flags.
module tb_regfile_scoreboard;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister, issue_reg;
  logic [63:0] ReadData1, ReadData2, WriteData;
  logic        busy1, busy2, RegWrite, issue_valid;
  logic [5:0]  busy_count;

  int n_checks = 0;
  int n_fails  = 0;

  logic [63:0] m_regs [0:31];
  bit          m_pend [0:31];

  regfile_scoreboard dut (
    .clock(clock), .reset_n(reset_n),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .busy1(busy1), .busy2(busy2),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .busy_count(busy_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 64'd0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  // Expected {busy, data} for a read index given the current model state and inputs.
  function automatic logic [64:0] model_read(input logic [4:0] idx);
    logic [64:0] r;
    if (idx == 5'd31) r = 65'd0;
    else r = {m_pend[idx], m_regs[idx]};
`ifdef REGFILE_BYPASS_EN
    if (idx != 5'd31 && RegWrite && WriteRegister == idx)
      r = {m_pend[idx] & issue_valid & (issue_reg == idx), WriteData};
`endif
    return r;
  endfunction

  task automatic model_edge();
    if (RegWrite && WriteRegister != 5'd31) begin
      m_regs[WriteRegister] = WriteData;
      m_pend[WriteRegister] = 1'b0;
    end
    if (issue_valid && issue_reg != 5'd31) m_pend[issue_reg] = 1'b1;
  endtask

  task automatic check_outputs(input string where);
    logic [64:0] e1, e2;
    e1 = model_read(ReadRegister1);
    e2 = model_read(ReadRegister2);
    check_eq({where, "/rd1"}, ReadData1, e1[63:0]);
    check_eq({where, "/busy1"}, {63'd0, busy1}, {63'd0, e1[64]});
    check_eq({where, "/rd2"}, ReadData2, e2[63:0]);
    check_eq({where, "/busy2"}, {63'd0, busy2}, {63'd0, e2[64]});
    check_eq({where, "/count"}, {58'd0, busy_count}, 64'(model_count()));
  endtask

  task automatic cycle(input logic we, input logic [4:0] wr, input logic [63:0] wd,
                       input logic iv, input logic [4:0] ir,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clock);
    RegWrite = we; WriteRegister = wr; WriteData = wd;
    issue_valid = iv; issue_reg = ir;
    ReadRegister1 = r1; ReadRegister2 = r2;
    #1 check_outputs("pre");
    @(posedge clock);
    model_edge();
    #1 check_outputs("post");
  endtask

  // Reset asserted away from the clock edge, with traffic that must be ignored.
  task automatic mid_reset();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 model_clear();
    check_outputs("rst");
    RegWrite = 1'b1; WriteRegister = 5'd6; WriteData = 64'hFFFF_0000_FFFF_0000;
    issue_valid = 1'b1; issue_reg = 5'd6;
    @(posedge clock);
    #1 check_outputs("rst_hold");
    @(negedge clock);
    RegWrite = 1'b0; issue_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic sweep_reads(input string where);
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #1 check_outputs(where);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    RegWrite = 1'b0; WriteRegister = 5'd0; WriteData = 64'd0;
    issue_valid = 1'b0; issue_reg = 5'd0;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
    model_clear();
    #12 sweep_reads("init");
    @(negedge clock);
    reset_n = 1'b1;

    // Reset clears a written register immediately
    cycle(1'b1, 5'd5, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 5'd5, 5'd5, 5'd5);
    check_eq("x5_written", ReadData1, 64'hDEAD_BEEF_CAFE_F00D);
    mid_reset();
    check_eq("x5_after_reset", ReadData1, 64'd0);
    check_eq("count_after_reset", {58'd0, busy_count}, 64'd0);
    sweep_reads("post_rst");

    // Write/read and XZR
    cycle(1'b1, 5'd3, 64'h1234, 1'b0, 5'd0, 5'd3, 5'd31);
    cycle(1'b1, 5'd31, 64'hFFFF, 1'b0, 5'd0, 5'd3, 5'd31);
    cycle(1'b0, 5'd3, 64'h5555, 1'b0, 5'd0, 5'd3, 5'd31);
    check_eq("x3_hold", ReadData1, 64'h1234);
    check_eq("x31_zero", ReadData2, 64'd0);

    // Scoreboard lifecycle
    cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 5'd7, 5'd0);
    check_eq("x7_busy", {63'd0, busy1}, 64'd1);
    check_eq("x7_count", {58'd0, busy_count}, 64'd1);
    cycle(1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 5'd7, 5'd0);
    check_eq("x7_clear", {63'd0, busy1}, 64'd0);

    // Simultaneous set/clear
    cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 5'd9, 5'd2);
    cycle(1'b1, 5'd9, 64'h99, 1'b1, 5'd9, 5'd9, 5'd2);
    check_eq("x9_still_busy", {63'd0, busy1}, 64'd1);
    cycle(1'b1, 5'd9, 64'h999, 1'b1, 5'd2, 5'd9, 5'd2);
    check_eq("x2_x9_count", {58'd0, busy_count}, 64'd1);
    cycle(1'b1, 5'd2, 64'h22, 1'b0, 5'd0, 5'd9, 5'd2);

    // Write to X4 while reading it; expected value depends on the forwarding build
    cycle(1'b1, 5'd4, 64'h11, 1'b0, 5'd0, 5'd0, 5'd4);
    cycle(1'b1, 5'd4, 64'hAA, 1'b0, 5'd0, 5'd0, 5'd4);
    check_eq("x4_after_edge", ReadData2, 64'hAA);

    // Fill the scoreboard, including a no-op issue to X31
    for (int i = 0; i < 32; i++) cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'(i), 5'(i), 5'd31);
    check_eq("fill_count", {58'd0, busy_count}, 64'd31);
    check_eq("fill_x31_idle", {63'd0, busy2}, 64'd0);
    for (int i = 0; i < 31; i++)
      cycle(1'b1, 5'(i), {$urandom, $urandom}, 1'b0, 5'd0, 5'(i), 5'(30 - i));
    check_eq("drain_count", {58'd0, busy_count}, 64'd0);

    // Random traffic with one asynchronous reset in the middle
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr, ir, r1, r2;
      wr = 5'($urandom_range(0, 31));
      ir = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? ir : 5'($urandom_range(0, 31));
      cycle(1'($urandom_range(0, 1)), wr, {$urandom, $urandom},
            1'($urandom_range(0, 1)), ir, r1, r2);
      if (n == 200) mid_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
